// File: rtl/huffman_sequencer_if.sv
// Symbol stream and LUT configuration port of the Huffman sequencer.
interface huffman_sequencer_if;
  logic        cfg_write;
  logic [5:0]  cfg_addr;
  logic [11:0] cfg_data;
  logic        sym_valid;
  logic [5:0]  sym_data;
  logic        sym_last;
  logic        sym_ready;

  modport master (
    output cfg_write, cfg_addr, cfg_data, sym_valid, sym_data, sym_last,
    input  sym_ready
  );

  modport slave (
    input  cfg_write, cfg_addr, cfg_data, sym_valid, sym_data, sym_last,
    output sym_ready
  );
endinterface

// File: rtl/huffman_sequencer.sv
// Huffman coder sequencer: loads the code LUT, reads one entry per symbol,
// pulses the serial coder, waits out the code length, then finalizes frames.
module huffman_sequencer #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              resetn,
  huffman_sequencer_if.slave s,
  input  logic              clr,
  output logic              ram_mode,
  output logic [5:0]        ram_addr,
  output logic [11:0]       ram_data,
  input  logic [11:0]       ram_q,
  output logic              coder_ce,
  output logic [7:0]        coder_code,
  output logic [LEN_W-1:0]  coder_length,
  output logic              coder_finalize,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sym_count,
  output logic [CNT_W-1:0]  bit_count,
  output logic              err_zero_len,
  output logic              err_cfg
);

  typedef enum logic [2:0] {IDLE, LOAD, READ, ISSUE, WAIT, FINAL} state_t;

  state_t           state, state_nxt;
  logic             last_q;
  logic [LEN_W-1:0] wcnt;
  logic [LEN_W-1:0] q_len;
  logic             q_zero;
  logic [CNT_W:0]   bit_sum;

  assign q_len   = ram_q[LEN_W-1:0];
  assign q_zero  = (q_len == '0);
  // One extra bit catches the carry so the add can saturate instead of wrap.
  assign bit_sum = {1'b0, bit_count} + {{(CNT_W+1-LEN_W){1'b0}}, q_len};

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; a config write beats a pending symbol in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s.cfg_write)      state_nxt = LOAD;
               else if (s.sym_valid) state_nxt = READ;
      LOAD:    state_nxt = IDLE;
      READ:    state_nxt = ISSUE;
      ISSUE:   if (!q_zero)          state_nxt = WAIT;
               else if (last_q)      state_nxt = FINAL;
               else                  state_nxt = IDLE;
      WAIT:    if (wcnt <= LEN_W'(1)) state_nxt = last_q ? FINAL : IDLE;
      FINAL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: coder is driven straight from the LUT read data in ISSUE
  always_comb begin
    s.sym_ready    = (state == IDLE) && !s.cfg_write;
    busy           = (state != IDLE);
    coder_ce       = 1'b0;
    coder_finalize = 1'b0;
    coder_code     = '0;
    coder_length   = '0;
    if (state == ISSUE && !q_zero) begin
      coder_ce     = 1'b1;
      coder_code   = ram_q[11:4];
      coder_length = q_len;
    end
    if (state == FINAL) begin
      coder_ce       = 1'b1;
      coder_finalize = 1'b1;
    end
  end

  // RAM address/data/mode registers, frame-end latch, serialisation counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ram_mode <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      last_q   <= 1'b0;
      wcnt     <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == FINAL);
      case (state)
        IDLE: begin
          if (s.cfg_write) begin
            ram_addr <= s.cfg_addr;
            ram_data <= s.cfg_data;
            ram_mode <= 1'b1;
          end else if (s.sym_valid) begin
            ram_addr <= s.sym_data;
            ram_mode <= 1'b0;
            last_q   <= s.sym_last;
          end
        end
        LOAD:    ram_mode <= 1'b0;
        ISSUE:   wcnt     <= q_len;
        WAIT:    wcnt     <= wcnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Statistics and sticky errors; clr overrides any same-cycle update
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sym_count    <= '0;
      bit_count    <= '0;
      err_zero_len <= 1'b0;
      err_cfg      <= 1'b0;
    end else if (clr) begin
      sym_count    <= '0;
      bit_count    <= '0;
      err_zero_len <= 1'b0;
      err_cfg      <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        if (q_zero) begin
          err_zero_len <= 1'b1;
        end else begin
          if (sym_count != '1) sym_count <= sym_count + 1'b1;
          bit_count <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
        end
      end
      if (s.cfg_write && state != IDLE) err_cfg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_huffman_sequencer.sv
// Bench for huffman_sequencer: behavioural LUT RAM, table-driven symbol
// vectors, scoreboard of expected coder pulses, hand-written corner cases.
module tb_huffman_sequencer;
  localparam int LEN_W = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              resetn;
  logic              clr;
  logic              ram_mode;
  logic [5:0]        ram_addr;
  logic [11:0]       ram_data;
  logic [11:0]       ram_q;
  logic              coder_ce, coder_finalize, busy, done;
  logic [7:0]        coder_code;
  logic [LEN_W-1:0]  coder_length;
  logic [CNT_W-1:0]  sym_count, bit_count;
  logic              err_zero_len, err_cfg;

  huffman_sequencer_if sif();

  huffman_sequencer #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .resetn(resetn), .s(sif.slave), .clr(clr),
    .ram_mode(ram_mode), .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q),
    .coder_ce(coder_ce), .coder_code(coder_code), .coder_length(coder_length),
    .coder_finalize(coder_finalize), .busy(busy), .done(done),
    .sym_count(sym_count), .bit_count(bit_count),
    .err_zero_len(err_zero_len), .err_cfg(err_cfg)
  );

  always #5 clock = ~clock;

  // Behavioural memory_unit: write when mode=1, registered read when mode=0
  logic [11:0] mem [64] = '{default: 12'h000};
  always @(posedge clock) begin
    if (ram_mode) mem[ram_addr] <= ram_data;
    else          ram_q         <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int exp_sym = 0;
  int exp_bits = 0;

  typedef struct { logic [7:0] code; logic [3:0] len; int due; } exp_t;
  typedef struct { logic [5:0] sym; logic last; logic [7:0] code; logic [3:0] len; } vec_t;
  typedef struct { logic [5:0] addr; logic [7:0] code; logic [3:0] len; } cfg_t;

  exp_t sbq[$];
  int   finq[$];
  int   doneq[$];
  exp_t me;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Coder-side monitor: every coder pulse must match the head of its queue
  always @(negedge clock) begin
    if (resetn) begin
      if (coder_ce && !coder_finalize) begin
        if (sbq.size() == 0) begin
          n_chk++;
          $display("FAIL ce_unexpected: coder_ce with code %0h at cycle %0d, nothing pending", coder_code, cyc);
        end else begin
          me = sbq.pop_front();
          chk("ce_code", coder_code, me.code);
          chk("ce_len", coder_length, me.len);
          chk("ce_cycle", cyc, me.due);
        end
      end
      if (coder_finalize) begin
        if (finq.size() == 0) begin
          n_chk++;
          $display("FAIL fin_unexpected: coder_finalize at cycle %0d", cyc);
        end else begin
          chk("fin_cycle", cyc, finq.pop_front());
          chk("fin_ce", coder_ce, 1);
          chk("fin_codelen", {coder_code, coder_length}, 0);
        end
      end
      if (done) begin
        if (doneq.size() == 0) begin
          n_chk++;
          $display("FAIL done_unexpected: done at cycle %0d", cyc);
        end else chk("done_cycle", cyc, doneq.pop_front());
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, sif.sym_ready, 1);
    chk({tag, "_mode"}, ram_mode, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_data"}, ram_data, 0);
    chk({tag, "_ce"}, coder_ce, 0);
    chk({tag, "_fin"}, coder_finalize, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_symcnt"}, sym_count, 0);
    chk({tag, "_bitcnt"}, bit_count, 0);
    chk({tag, "_errz"}, err_zero_len, 0);
    chk({tag, "_errc"}, err_cfg, 0);
  endtask

  // Present a symbol until accepted; queue its expected coder activity
  task automatic send(input logic [5:0] sym, input logic last, input logic [7:0] code,
                      input logic [3:0] len, output int acc);
    exp_t e;
    int   f;
    sif.sym_valid = 1'b1;
    sif.sym_data  = sym;
    sif.sym_last  = last;
    acc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (sif.sym_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      n_chk++;
      $display("FAIL accept_timeout: symbol %0d never accepted", sym);
    end else begin
      if (len != 0) begin
        e.code = code; e.len = len; e.due = acc + 2;
        sbq.push_back(e);
        if (exp_sym < CMAX) exp_sym++;
        exp_bits = (exp_bits + int'(len) > CMAX) ? CMAX : exp_bits + int'(len);
      end
      if (last) begin
        f = (len != 0) ? acc + 3 + int'(len) : acc + 3;
        finq.push_back(f);
        doneq.push_back(f + 1);
      end
    end
    @(posedge clock); #1;
    sif.sym_valid = 1'b0;
    sif.sym_last  = 1'b0;
  endtask

  task automatic cfg(input logic [5:0] addr, input logic [7:0] code, input logic [3:0] len);
    sif.cfg_write = 1'b1;
    sif.cfg_addr  = addr;
    sif.cfg_data  = {code, len};
    @(posedge clock); #1;
    sif.cfg_write = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL idle_timeout: busy stuck high at cycle %0d", cyc);
    end
    @(posedge clock); #1;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(posedge clock); #1;
    clr = 1'b0;
    exp_sym = 0;
    exp_bits = 0;
  endtask

  task automatic at_neg(input int target);
    do @(negedge clock); while (cyc < target);
  endtask

  cfg_t ct[7];
  vec_t vt[7];
  int   a, a2, t;

  initial begin
    ct[0] = '{6'd3,  8'h3C, 4'd4};
    ct[1] = '{6'd10, 8'h01, 4'd1};
    ct[2] = '{6'd20, 8'h00, 4'd0};
    ct[3] = '{6'd63, 8'hFF, 4'd8};
    ct[4] = '{6'd0,  8'h5A, 4'd3};
    ct[5] = '{6'd9,  8'h99, 4'd15};
    ct[6] = '{6'd7,  8'h00, 4'd1};

    vt[0] = '{6'd5,  1'b0, 8'hA5, 4'd8};
    vt[1] = '{6'd3,  1'b0, 8'h3C, 4'd4};
    vt[2] = '{6'd10, 1'b0, 8'h01, 4'd1};
    vt[3] = '{6'd63, 1'b0, 8'hFF, 4'd8};
    vt[4] = '{6'd0,  1'b0, 8'h5A, 4'd3};
    vt[5] = '{6'd20, 1'b0, 8'h00, 4'd0};
    vt[6] = '{6'd5,  1'b1, 8'hA5, 4'd8};

    resetn = 1'b0; clr = 1'b0;
    sif.cfg_write = 1'b0; sif.cfg_addr = '0; sif.cfg_data = '0;
    sif.sym_valid = 1'b0; sif.sym_data = '0; sif.sym_last = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset("rst");
    resetn = 1'b1;
    @(posedge clock); #1;

    // LUT write of entry 5: ram_mode high for exactly the LOAD cycle
    sif.cfg_write = 1'b1; sif.cfg_addr = 6'd5; sif.cfg_data = 12'hA58;
    @(negedge clock);
    chk("cfg_blocks_ready", sif.sym_ready, 0);
    @(posedge clock); #1;
    sif.cfg_write = 1'b0;
    @(negedge clock);
    chk("load_mode", ram_mode, 1);
    chk("load_addr", ram_addr, 6'd5);
    chk("load_data", ram_data, 12'hA58);
    chk("load_busy", busy, 1);
    @(negedge clock);
    chk("load_mode_drop", ram_mode, 0);
    chk("load_errcfg", err_cfg, 0);
    chk("load_idle", busy, 0);
    @(posedge clock); #1;
    foreach (ct[i]) cfg(ct[i].addr, ct[i].code, ct[i].len);

    // Table-driven symbol stream
    foreach (vt[i]) send(vt[i].sym, vt[i].last, vt[i].code, vt[i].len, a);
    wait_idle();
    chk("tbl_symcnt", sym_count, exp_sym);
    chk("tbl_bitcnt", bit_count, exp_bits);
    chk("tbl_errz", err_zero_len, 1);

    // Back-to-back length-8 symbols: accepts 11 cycles apart
    clr_pulse();
    send(6'd5, 1'b0, 8'hA5, 4'd8, a);
    send(6'd5, 1'b0, 8'hA5, 4'd8, a2);
    chk("b2b_gap", a2 - a, 11);
    wait_idle();
    chk("b2b_symcnt", sym_count, 2);
    chk("b2b_bitcnt", bit_count, 16);

    // Last symbol: finalize at t+11, done and idle at t+12
    send(6'd5, 1'b1, 8'hA5, 4'd8, a);
    at_neg(a + 11);
    chk("last_fin", coder_finalize, 1);
    at_neg(a + 12);
    chk("last_done", done, 1);
    chk("last_busy", busy, 0);
    chk("last_ready", sif.sym_ready, 1);
    @(posedge clock); #1;

    // Zero-length entry: no coder pulse, error flag, ready again at t+3
    clr_pulse();
    send(6'd20, 1'b0, 8'h00, 4'd0, a);
    at_neg(a + 2);
    chk("zl_no_ce", coder_ce, 0);
    at_neg(a + 3);
    chk("zl_ready", sif.sym_ready, 1);
    chk("zl_errz", err_zero_len, 1);
    chk("zl_symcnt", sym_count, 0);
    @(posedge clock); #1;

    // Config write during WAIT is dropped and flagged
    send(6'd5, 1'b0, 8'hA5, 4'd8, a);
    repeat (3) begin @(posedge clock); #1; end
    sif.cfg_write = 1'b1; sif.cfg_addr = 6'd5; sif.cfg_data = {8'h11, 4'd2};
    @(posedge clock); #1;
    sif.cfg_write = 1'b0;
    @(negedge clock);
    chk("wcfg_errcfg", err_cfg, 1);
    chk("wcfg_busy", busy, 1);
    wait_idle();
    send(6'd5, 1'b0, 8'hA5, 4'd8, a);
    wait_idle();

    // clr drops sticky flags; then cfg and symbol in the same IDLE cycle
    clr_pulse();
    @(negedge clock);
    chk("clr_errcfg", err_cfg, 0);
    chk("clr_errz", err_zero_len, 0);
    @(posedge clock); #1;
    t = cyc;
    sif.cfg_write = 1'b1; sif.cfg_addr = 6'd7; sif.cfg_data = {8'h77, 4'd2};
    sif.sym_valid = 1'b1; sif.sym_data = 6'd7;
    @(negedge clock);
    chk("both_ready", sif.sym_ready, 0);
    @(posedge clock); #1;
    sif.cfg_write = 1'b0;
    send(6'd7, 1'b0, 8'h77, 4'd2, a);
    chk("both_acc", a, t + 2);
    wait_idle();

    // bit_count saturation: 240+8+4 = 252, then +8 clamps at 255
    clr_pulse();
    repeat (16) send(6'd9, 1'b0, 8'h99, 4'd15, a);
    send(6'd5, 1'b0, 8'hA5, 4'd8, a);
    send(6'd3, 1'b0, 8'h3C, 4'd4, a);
    wait_idle();
    chk("sat_pre", bit_count, 8'hFC);
    send(6'd5, 1'b0, 8'hA5, 4'd8, a);
    wait_idle();
    chk("sat_bits", bit_count, 8'hFF);

    // sym_count saturation
    clr_pulse();
    repeat (258) send(6'd10, 1'b0, 8'h01, 4'd1, a);
    wait_idle();
    chk("sat_syms", sym_count, 8'hFF);
    chk("sat_syms_model", sym_count, exp_sym);

    // clr in the ISSUE cycle wins over the counter update
    send(6'd5, 1'b0, 8'hA5, 4'd8, a);
    @(posedge clock); #1;
    clr = 1'b1;
    @(posedge clock); #1;
    clr = 1'b0;
    exp_sym = 0; exp_bits = 0;
    @(negedge clock);
    chk("clrissue_sym", sym_count, 0);
    chk("clrissue_bit", bit_count, 0);
    wait_idle();

    // Asynchronous reset in the middle of WAIT
    send(6'd5, 1'b0, 8'hA5, 4'd8, a);
    repeat (3) begin @(posedge clock); #1; end
    #2 resetn = 1'b0;
    #1 chk_reset("rstwait");
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock); #1;
    repeat (3) @(negedge clock);

    chk("sb_empty", sbq.size(), 0);
    chk("fin_empty", finq.size(), 0);
    chk("done_empty", doneq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/huffman_sequencer.md
# huffman_sequencer

Controller that feeds the Huffman coder datapath from a symbol stream. It owns the 64-entry code LUT (memory_unit) and the serial coder (coder), and sequences LUT loading, the one-cycle LUT read latency, per-symbol coder enables and end-of-frame finalize. It also keeps symbol/bit statistics for the Avalon-side register file. It replaces ad-hoc chipselect-driven sequencing with a deterministic state machine.

## Interface
- LEN_W, 4, width of LUT length field (code length 0..15; coder limited to 1..8)
- CNT_W, 16, width of statistic counters
- clock  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of sym_count, bit_count, err_zero_len, err_cfg
- cfg_write  in  1  LUT write strobe (one entry per cycle)
- cfg_addr  in  6  LUT entry address (= symbol)
- cfg_data  in  12  LUT entry: [11:4] code, [3:0] length
- sym_valid  in  1  input symbol valid
- sym_data  in  6  input symbol
- sym_last  in  1  symbol is last of frame (finalize after it)
- sym_ready  out  1  symbol accepted when sym_valid & sym_ready
- ram_mode  out  1  to memory_unit modeselect: 1 write, 0 read
- ram_addr  out  6  to memory_unit addr (registered)
- ram_data  out  12  to memory_unit data (registered)
- ram_q  in  12  memory_unit data_out, valid 1 cycle after address presented in read mode
- coder_ce  out  1  coder clock enable, one-cycle pulse per code
- coder_code  out  8  = ram_q[11:4] while coder_ce
- coder_length  out  4  = ram_q[3:0] while coder_ce
- coder_finalize  out  1  coder finalize, high only with coder_ce in FINAL
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after finalize issued
- sym_count  out  CNT_W  symbols encoded, saturating
- bit_count  out  CNT_W  sum of code lengths issued, saturating
- err_zero_len  out  1  sticky: a symbol hit a zero-length entry
- err_cfg  out  1  sticky: cfg_write arrived while busy

## Operation
- States: IDLE, LOAD, READ, ISSUE, WAIT, FINAL.
- IDLE: sym_ready=1 unless cfg_write=1. cfg_write has priority: latch cfg_addr/cfg_data into ram_addr/ram_data, ram_mode<=1, go LOAD. Else on sym_valid: ram_addr<=sym_data, ram_mode<=0, latch sym_last, go READ.
- LOAD: one cycle, RAM samples write; ram_mode<=0; back to IDLE. Back-to-back writes: one per 2 cycles.
- READ: RAM samples read address; go ISSUE.
- ISSUE: ram_q valid. If length≠0: coder_ce=1, coder_code/coder_length from ram_q, sym_count+1, bit_count+length, load wait counter with length, go WAIT. If length=0: no coder_ce, set err_zero_len, counters unchanged, go FINAL if last else IDLE.
- WAIT: coder serialises one bit per cycle; decrement counter; at count=1 go FINAL if last latched, else IDLE.
- FINAL: coder_ce=1, coder_finalize=1, coder_code/length=0 for one cycle; next cycle done=1, state IDLE.
- cfg_write outside IDLE: ignored, err_cfg set; stream unaffected.
- Counters saturate at 2^CNT_W-1; bit_count add saturates rather than wraps.
- clr same cycle as a counter update: clr wins (counter result 0).
- sym_ready low outside IDLE; a symbol held valid waits without loss.

## Timing
- Reset: state IDLE, sym_ready=1, ram_mode=0, ram_addr=0, ram_data=0, coder_ce=0, coder_finalize=0, busy=0, done=0, counters 0, error flags 0. Reset mid-frame aborts immediately; coder state is owned by coder's own reset.
- Symbol accepted at cycle t: READ t+1, coder_ce at t+2, WAIT t+3..t+2+L, IDLE (sym_ready) at t+3+L. Throughput L+3 cycles per symbol.
- Last symbol: FINAL at t+3+L, done at t+4+L, sym_ready at t+4+L.
- Zero-length symbol: no coder_ce; sym_ready again at t+3.
- cfg write at t: RAM written on edge ending t+1; symbol may be accepted at t+2 and reads the new value.

## Test plan
- Reset then load addr 5 = code 0xA5, len 8 -> ram_mode=1 for 1 cycle, err_cfg=0; later symbol 5 gives coder_code=0xA5, coder_length=8 exactly 2 cycles after accept.
- Symbols 5,5 (len 8) back-to-back with sym_valid held -> coder_ce pulses 11 cycles apart, sym_count=2, bit_count=16.
- Symbol 5 with sym_last=1 -> coder_ce at t+2, coder_finalize+coder_ce at t+11, done at t+12, busy low at t+12.
- Symbol pointing to entry with len 0 -> no coder_ce, err_zero_len=1, sym_count unchanged, sym_ready at t+3.
- cfg_write during WAIT -> ignored, err_cfg=1, LUT entry unchanged on later read; cfg_write and sym_valid same IDLE cycle -> write taken, symbol accepted 2 cycles later.
- bit_count preset near 0xFFFC, issue len 8 -> bit_count=0xFFFF; clr with simultaneous ISSUE -> counters 0; resetn low in WAIT -> all outputs at reset values asynchronously.
